// File: rtl/reg_skid_pkg.sv
// Shared types and constants for the reg_skid_hs elastic pipeline register.
// State encoding mirrors (main_v, skid_v) so the valid bits fall out of the state directly.
package reg_skid_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      TWO   = 2'b11
   } state_e;

   localparam int unsigned STALL_CNT_W = 16;
   localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

   // Saturating increment for the stall counter.
   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      return (v == STALL_CNT_MAX) ? v : v + STALL_CNT_W'(1);
   endfunction

endpackage

// File: rtl/reg_skid_hs_if.sv
// Valid/ready handshake bundle for reg_skid_hs: upstream (in_*) and downstream (out_*) sides.
// slave is the stage itself; master is whatever drives it and consumes its output.
interface reg_skid_hs_if #(
   parameter int unsigned DATA_W = 32
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

endinterface

// File: rtl/reg_skid_hs_data_reg.sv
// Payload register with load enable and synchronous preset.
// Preset has priority over load so reset/flush always leave a known value.
module skid_data_reg #(
   parameter int unsigned          DATA_W     = 32,
   parameter logic [DATA_W-1:0]    PRESET_VAL = '0
) (
   input  logic              clk,
   input  logic              i_clr,
   input  logic              i_ld,
   input  logic [DATA_W-1:0] i_d,
   output logic [DATA_W-1:0] o_q
);

   logic [DATA_W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_q <= PRESET_VAL;
      end else if (i_ld) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/reg_skid_hs.sv
// Two-entry elastic pipeline register (main + skid) with registered in_ready.
// Optional saturating stall counter output when REG_SKID_STALL_CNT_EN is defined.
module reg_skid_hs
   import reg_skid_pkg::*;
#(
   parameter int unsigned       DATA_W     = 32,
   parameter logic [DATA_W-1:0] PRESET_VAL = '0
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             flush,
   reg_skid_hs_if.slave     bus
`ifdef REG_SKID_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

   state_e            r_state;
   state_e            w_state_nxt;
   logic              r_in_ready;
   logic              r_out_valid;
   logic              w_in_ready_nxt;
   logic              w_out_valid_nxt;
   logic              w_in_xfer;
   logic              w_out_xfer;
   logic              w_main_ld;
   logic              w_main_from_skid;
   logic              w_skid_ld;
   logic              w_clr;
   logic [DATA_W-1:0] w_main_d;
   logic [DATA_W-1:0] w_main_q;
   logic [DATA_W-1:0] w_skid_q;

   assign w_in_xfer  = bus.in_valid & r_in_ready;
   assign w_out_xfer = r_out_valid & bus.out_ready;
   assign w_clr      = arst | flush;

   // State and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (arst) begin
         r_state     <= EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_in_ready  <= w_in_ready_nxt;
      end
   end

   // Next-state and data-register enables; flush discards everything including a same-cycle accept.
   always_comb begin
      w_state_nxt      = r_state;
      w_main_ld        = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_ld        = 1'b0;

      case (r_state)
         EMPTY: begin
            if (w_in_xfer) begin
               w_main_ld   = 1'b1;
               w_state_nxt = ONE;
            end
         end
         ONE: begin
            if (w_in_xfer && w_out_xfer) begin
               w_main_ld = 1'b1;
            end else if (w_in_xfer) begin
               w_skid_ld   = 1'b1;
               w_state_nxt = TWO;
            end else if (w_out_xfer) begin
               w_state_nxt = EMPTY;
            end
         end
         TWO: begin
            if (w_out_xfer) begin
               w_main_ld        = 1'b1;
               w_main_from_skid = 1'b1;
               w_state_nxt      = ONE;
            end
         end
         default: begin
            w_state_nxt = EMPTY;
         end
      endcase

      if (flush) begin
         w_state_nxt = EMPTY;
         w_main_ld   = 1'b0;
         w_skid_ld   = 1'b0;
      end

      w_out_valid_nxt = (w_state_nxt != EMPTY);
      w_in_ready_nxt  = (w_state_nxt != TWO);
   end

   assign w_main_d = w_main_from_skid ? w_skid_q : bus.in_data;

   skid_data_reg #(
      .DATA_W     (DATA_W),
      .PRESET_VAL (PRESET_VAL)
   ) u_main (
      .clk   (clk),
      .i_clr (w_clr),
      .i_ld  (w_main_ld),
      .i_d   (w_main_d),
      .o_q   (w_main_q)
   );

   skid_data_reg #(
      .DATA_W     (DATA_W),
      .PRESET_VAL (PRESET_VAL)
   ) u_skid (
      .clk   (clk),
      .i_clr (w_clr),
      .i_ld  (w_skid_ld),
      .i_d   (bus.in_data),
      .o_q   (w_skid_q)
   );

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = w_main_q;

   // Handshake registers must always agree with the state; (0,1) is unreachable.
   always_ff @(posedge clk) begin
      if (!arst) begin
         assert (r_state == EMPTY || r_state == ONE || r_state == TWO);
         assert (r_in_ready == (r_state != TWO));
         assert (r_out_valid == (r_state != EMPTY));
      end
   end

`ifdef REG_SKID_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   // Counts back-pressured cycles; only reset clears it, flush does not.
   always_ff @(posedge clk) begin
      if (arst) begin
         r_stall_cnt <= '0;
      end else if (r_out_valid && !bus.out_ready) begin
         r_stall_cnt <= sat_inc(r_stall_cnt);
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_reg_skid_hs.sv
// Self-checking bench for reg_skid_hs: directed scenarios plus random traffic against a queue model.
// Define REG_SKID_STALL_CNT_EN to also exercise the stall counter.
module tb_reg_skid_hs;

   localparam int unsigned DW = 32;
   localparam logic [DW-1:0] PV = 32'h5A5A_0F0F;

   logic clk;
   logic arst;
   logic flush;

   reg_skid_hs_if #(.DATA_W(DW)) bus ();

`ifdef REG_SKID_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   reg_skid_hs #(
      .DATA_W     (DW),
      .PRESET_VAL (PV)
   ) dut (
      .clk   (clk),
      .arst  (arst),
      .flush (flush),
      .bus   (bus)
`ifdef REG_SKID_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Reference model: an ordered queue of at most two entries, plus the last head value.
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] m_head = PV;
   int            m_stall = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit mv;
      bit in_x;
      bit out_x;
      mv    = (m_q.size() != 0);
      in_x  = bus.in_valid && (m_q.size() < 2);
      out_x = mv && bus.out_ready;
      if (arst) begin
         m_q.delete();
         m_head  = PV;
         m_stall = 0;
      end else begin
         if (mv && !bus.out_ready && m_stall < 65535) m_stall++;
         if (flush) begin
            m_q.delete();
            m_head = PV;
         end else begin
            if (out_x) void'(m_q.pop_front());
            if (in_x) m_q.push_back(bus.in_data);
            if (m_q.size() != 0) m_head = m_q[0];
         end
      end
   endtask

   // Every cycle: compare the DUT against the model on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
         chk("in_ready", 32'(bus.in_ready), 32'(m_q.size() < 2));
         chk("out_data", bus.out_data, m_head);
`ifdef REG_SKID_STALL_CNT_EN
         chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
      end
   end

   task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                       input logic fl, input logic rs);
      @(negedge clk);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      flush         = fl;
      arst          = rs;
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      arst          = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk_en = 1'b1;
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst out_data", bus.out_data, 32'h5A5A_0F0F);

      // Full-throughput stream.
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
         chk("stream out_data", bus.out_data, 32'(i));
         chk("stream in_ready", 32'(bus.in_ready), 32'd1);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("stream drain", 32'(bus.out_valid), 32'd0);

      // Fill to TWO and hold under back-pressure.
      step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
      chk("two in_ready", 32'(bus.in_ready), 32'd0);
      chk("two out_data", bus.out_data, 32'hA);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
         chk("hold out_data", bus.out_data, 32'hA);
         chk("hold out_valid", 32'(bus.out_valid), 32'd1);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("pop1 out_data", bus.out_data, 32'hB);
      chk("pop1 in_ready", 32'(bus.in_ready), 32'd1);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("pop2 out_valid", 32'(bus.out_valid), 32'd0);

      // Flush while full with a pending input.
      step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h33, 1'b0, 1'b1, 1'b0);
      chk("flush out_valid", 32'(bus.out_valid), 32'd0);
      chk("flush in_ready", 32'(bus.in_ready), 32'd1);
      chk("flush out_data", bus.out_data, 32'h5A5A_0F0F);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("flush idle", 32'(bus.out_valid), 32'd0);

      // Reset while full.
      step(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h66, 1'b0, 1'b0, 1'b1);
      chk("arst out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst out_data", bus.out_data, 32'h5A5A_0F0F);
      chk("arst in_ready", 32'(bus.in_ready), 32'd1);
`ifdef REG_SKID_STALL_CNT_EN
      chk("arst stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
              $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
      end

`ifdef REG_SKID_STALL_CNT_EN
      // Long stall saturates the counter; flush must not clear it.
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 70000; i++) begin
         step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      end
      chk("stall sat", 32'(stall_cnt), 32'h0000_FFFF);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk("stall after flush", 32'(stall_cnt), 32'h0000_FFFF);
      chk("stall flush valid", 32'(bus.out_valid), 32'd0);
`endif

      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
